iic_slave: RTL
==============

# iic_slave

Target-side IIC block for the TangPrimer_20k IIC designs: responds to a 7-bit address, keeps an 8-bit register pointer, and turns bus transfers into single-cycle register write/read strobes. It is the far end of the existing IIC master and lets FPGA-side registers be loop-tested against it or exposed to an external controller. SCL and SDA are oversampled on the system clock; the block never drives SCL, so there is no clock stretching.

## Interface
- CLK_FRE, 50, system clock in MHz; must be ≥ 20 for 400 kHz bus operation.
- SLAVE_ADDR, 7'h3C, 7-bit device address this block answers to.
- FILTER_LEN, 3, consecutive equal samples required by the glitch filter (range 2..8).

- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- iic_scl  input  1  bus clock from the master.
- iic_sda  inout  1  open-drain data line: driven 0 or released to 'z', never driven 1.
- reg_addr  output  8  register pointer.
- reg_wr_en  output  1  one-cycle write strobe.
- reg_wr_data  output  8  write byte; valid while reg_wr_en=1.
- reg_rd_en  output  1  one-cycle read request for reg_addr.
- reg_rd_data  input  8  read byte; the block samples it exactly 1 cycle after reg_rd_en.
- busy  output  1  high from an address match to STOP, or to the next START.
- addr_hit  output  1  one-cycle pulse on address match.

## Operation
- Input path: 2-FF synchronizer on SCL and SDA, then the optional filter. Edge detection runs on the conditioned signals.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both take effect from any state.
  - START, including a repeated START, goes to ADDR with the bit counter cleared.
  - STOP goes to IDLE, releases SDA and clears busy.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- Bit handling:
  - Bits are sampled on SCL rising edges, MSB first.
  - SDA is changed only right after an SCL falling edge is detected.
- ADDR: after 8 bits, compare bits [7:1] with SLAVE_ADDR.
  - Mismatch: go to IGNORE (no ACK) until START or STOP.
  - Match: pulse addr_hit, set busy, drive ACK low for the 9th clock. Bit 0 = 0 selects REG; bit 0 = 1 selects RDATA.
- REG: the byte is loaded into reg_addr and ACKed. The next state is WDATA.
- WDATA: after 8 bits, place the byte on reg_wr_data and pulse reg_wr_en in the same cycle. ACK it. reg_addr increments when the ACK clock's SCL falling edge is detected.
- RDATA:
  - On the SCL falling edge that ends the ACK, pulse reg_rd_en.
  - Capture reg_rd_data into the shift register 1 cycle later and drive its MSB (low = drive 0, high = release).
  - Release SDA during the 9th clock and sample the master's ACK.
  - ACK (0): reg_addr increments, next byte.
  - NACK (1): go to IGNORE.
- reg_addr wraps 8'hFF → 8'h00.
- A START or STOP in the middle of a byte discards the partial byte: no strobe.
- rst at any time: state IDLE, SDA released, reg_addr=0, reg_wr_data=0, reg_wr_en=0, reg_rd_en=0, busy=0, addr_hit=0.

## Timing
- Pin-to-internal latency: 2 cycles without the filter, 2+FILTER_LEN cycles with it.
- SDA update lags the actual SCL falling edge by that latency plus 1 cycle. At CLK_FRE=50 with the filter off this is about 60 ns, inside the SCL low time.
- reg_wr_en: 1 cycle after the 8th data rising edge is detected.
- reg_rd_en → reg_rd_data sampled: 1 cycle. SDA is valid 2 cycles after reg_rd_en.
- START/STOP detection wins over any bit edge detected in the same cycle.

## Configuration
- IIC_SLAVE_GLITCH_FILTER_EN defined:
  - Each synchronized line passes through a FILTER_LEN-deep stability filter. The output changes only after FILTER_LEN consecutive equal samples.
  - Pulses shorter than FILTER_LEN cycles are suppressed.
- Undefined: no filter; the synchronizer output is used directly, and latency drops by FILTER_LEN.

## Test plan
- Write 0x78 (addr 0x3C, W), reg 0x10, data 0xA5, 0x5A, STOP → ACK on all 3 bytes. reg_wr_en pulses with (0x10,0xA5) then (0x11,0x5A). busy falls at STOP.
- Write reg 0x20, repeated START, 0x79 read 2 bytes (ACK then NACK), model returns reg_addr^0xFF → bus reads 0xDF, 0xDE; SDA released after NACK.
- Address 0x3D (W) with 3 data bytes → SDA never driven, no strobes, addr_hit=0.
- Write burst starting at reg 0xFF with 2 bytes → writes land at 0xFF then 0x00.
- STOP after 4 data bits → no reg_wr_en; next transaction behaves normally. rst asserted mid-read → SDA released next cycle, all outputs at reset values.
- With IIC_SLAVE_GLITCH_FILTER_EN and FILTER_LEN=3, inject a 2-cycle SCL glitch during a data bit → byte is still received correctly. With the macro undefined, the same glitch corrupts the bit count.

Source files
------------

// File: rtl/iic_slave_if.sv
// iic_slave_if: bus clock and register-side strobes of the IIC target.
// SDA stays a plain inout port on the target because it is open-drain.
interface iic_slave_if;
  logic       iic_scl;
  logic [7:0] reg_addr;
  logic       reg_wr_en;
  logic [7:0] reg_wr_data;
  logic       reg_rd_en;
  logic [7:0] reg_rd_data;
  logic       busy;
  logic       addr_hit;

  modport slave (
    input  iic_scl, reg_rd_data,
    output reg_addr, reg_wr_en, reg_wr_data,
    output reg_rd_en, busy, addr_hit
  );

  modport master (
    output iic_scl, reg_rd_data,
    input  reg_addr, reg_wr_en, reg_wr_data,
    input  reg_rd_en, busy, addr_hit
  );
endinterface

// File: rtl/iic_slave.sv
// iic_slave: IIC target, 7-bit address, auto-incrementing 8-bit register pointer.
// Define IIC_SLAVE_GLITCH_FILTER_EN to add a FILTER_LEN-deep input filter.
module iic_slave #(
  parameter int         CLK_FRE    = 50,
  parameter logic [6:0] SLAVE_ADDR = 7'h3C,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        iic_sda,
  iic_slave_if.slave bus
);

  if (CLK_FRE < 1 || FILTER_LEN < 2 || FILTER_LEN > 8) begin : g_cfg_check
    $error("iic_slave: unsupported CLK_FRE or FILTER_LEN");
  end

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  state_t state, state_n;

  logic scl_s1, scl_s2, sda_s1, sda_s2;
  logic scl_c, sda_c, scl_d, sda_d;

  // Bus idles high, so reset the input pipeline high to avoid false edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
    end else begin
      scl_s1 <= bus.iic_scl;
      scl_s2 <= scl_s1;
      sda_s1 <= iic_sda;
      sda_s2 <= sda_s1;
    end
  end

`ifdef IIC_SLAVE_GLITCH_FILTER_EN
  localparam int HW = FILTER_LEN - 1;
  logic [HW-1:0] scl_h, sda_h;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_h <= '1;
      sda_h <= '1;
      scl_c <= 1'b1;
      sda_c <= 1'b1;
    end else begin
      scl_h <= HW'({scl_h, scl_s2});
      sda_h <= HW'({sda_h, sda_s2});
      if (&{scl_h, scl_s2})
        scl_c <= 1'b1;
      else if (~|{scl_h, scl_s2})
        scl_c <= 1'b0;
      if (&{sda_h, sda_s2})
        sda_c <= 1'b1;
      else if (~|{sda_h, sda_s2})
        sda_c <= 1'b0;
    end
  end
`else
  assign scl_c = scl_s2;
  assign sda_c = sda_s2;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_c;
      sda_d <= sda_c;
    end
  end

  logic start, stop, scl_rise, scl_fall;
  assign start    = scl_d & scl_c & sda_d & ~sda_c;
  assign stop     = scl_d & scl_c & ~sda_d & sda_c;
  assign scl_rise = ~scl_d & scl_c;
  assign scl_fall = scl_d & ~scl_c;

  logic       phase, phase_n;
  logic [2:0] cnt, cnt_n;
  logic [6:0] shift, shift_n;
  logic       rw, rw_n;
  logic       mack, mack_n;
  logic       ld, ld_n;
  logic       oe, oe_n;
  logic [7:0] addr_q, addr_n;
  logic [7:0] wdata_q, wdata_n;
  logic       wr_q, wr_n;
  logic       rd_q, rd_n;
  logic       busy_q, busy_n;
  logic       hit_q, hit_n;
  logic [7:0] rx;

  assign rx = {shift, sda_c};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      phase   <= 1'b0;
      cnt     <= 3'd0;
      shift   <= 7'd0;
      rw      <= 1'b0;
      mack    <= 1'b1;
      ld      <= 1'b0;
      oe      <= 1'b0;
      addr_q  <= 8'd0;
      wdata_q <= 8'd0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state   <= state_n;
      phase   <= phase_n;
      cnt     <= cnt_n;
      shift   <= shift_n;
      rw      <= rw_n;
      mack    <= mack_n;
      ld      <= ld_n;
      oe      <= oe_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      wr_q    <= wr_n;
      rd_q    <= rd_n;
      busy_q  <= busy_n;
      hit_q   <= hit_n;
    end
  end

  always_comb begin
    state_n = state;
    phase_n = phase;
    cnt_n   = cnt;
    shift_n = shift;
    rw_n    = rw;
    mack_n  = mack;
    ld_n    = rd_q;
    oe_n    = oe;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    wr_n    = 1'b0;
    rd_n    = 1'b0;
    busy_n  = busy_q;
    hit_n   = 1'b0;

    if (start) begin
      state_n = ADDR;
      cnt_n   = 3'd0;
      phase_n = 1'b0;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else if (stop) begin
      state_n = IDLE;
      phase_n = 1'b0;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else begin
      unique case (state)
        ADDR, REG, WDATA: begin
          if (scl_rise) begin
            shift_n = rx[6:0];
            cnt_n   = cnt + 3'd1;
            phase_n = 1'b0;
            if (cnt == 3'd7) begin
              if (state == ADDR) begin
                if (rx[7:1] == SLAVE_ADDR) begin
                  hit_n   = 1'b1;
                  busy_n  = 1'b1;
                  rw_n    = rx[0];
                  state_n = ADDR_ACK;
                end else begin
                  state_n = IGNORE;
                end
              end else if (state == REG) begin
                addr_n  = rx;
                state_n = REG_ACK;
              end else begin
                wdata_n = rx;
                wr_n    = 1'b1;
                state_n = WDATA_ACK;
              end
            end
          end
        end
        ADDR_ACK, REG_ACK, WDATA_ACK: begin
          // First fall opens the ACK slot, second fall closes it.
          if (scl_fall) begin
            if (!phase) begin
              phase_n = 1'b1;
              oe_n    = 1'b1;
            end else begin
              phase_n = 1'b0;
              oe_n    = 1'b0;
              cnt_n   = 3'd0;
              if (state == ADDR_ACK) begin
                state_n = rw ? RDATA : REG;
                rd_n    = rw;
              end else begin
                state_n = WDATA;
              end
              if (state == WDATA_ACK)
                addr_n = addr_q + 8'd1;
            end
          end
        end
        RDATA: begin
          if (ld) begin
            shift_n = bus.reg_rd_data[6:0];
            oe_n    = ~bus.reg_rd_data[7];
          end else if (scl_fall) begin
            cnt_n   = cnt + 3'd1;
            shift_n = {shift[5:0], 1'b0};
            if (cnt == 3'd7) begin
              oe_n    = 1'b0;
              state_n = RDATA_ACK;
            end else begin
              oe_n = ~shift[6];
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            mack_n = sda_c;
          end else if (scl_fall) begin
            if (!mack) begin
              addr_n  = addr_q + 8'd1;
              rd_n    = 1'b1;
              cnt_n   = 3'd0;
              state_n = RDATA;
            end else begin
              state_n = IGNORE;
            end
          end
        end
        IDLE, IGNORE: ;
        default: state_n = IDLE;
      endcase
    end
  end

  assign iic_sda         = oe ? 1'b0 : 1'bz;
  assign bus.reg_addr    = addr_q;
  assign bus.reg_wr_en   = wr_q;
  assign bus.reg_wr_data = wdata_q;
  assign bus.reg_rd_en   = rd_q;
  assign bus.busy        = busy_q;
  assign bus.addr_hit    = hit_q;

endmodule
